// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the fetch PC, issues one imem read at a time,
// buffers the returned word for IF/ID and squashes in-flight fetches on redirect.
module ifu_fetch #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [PC_W-1:0]   imem_req_addr_o,
  input  logic              imem_resp_valid_i,
  input  logic [INST_W-1:0] imem_resp_data_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [INST_W-1:0] f_inst_o,
  output logic [PC_W-1:0]   f_pc_o,
  output logic [PC_W-1:0]   f_pred_pc_o
);

  localparam logic [INST_W-1:0] NOP = INST_W'(32'h13);

  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INST_W-1:0]   r_inst_buf;
  logic                r_drop;
  logic [PC_W-1:0]     w_pc_next;

  assign w_pc_next = r_pc + PC_W'(4);

  // Redirect wins over every other event; r_drop marks the one response still owed by memory as stale.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_inst_buf <= NOP;
    end else if (redirect_valid_i) begin
      r_pc <= redirect_pc_i;
      case (r_state)
        REQ: begin
          if (imem_req_ready_i) begin
            r_state <= WAIT;
            r_drop  <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_resp_valid_i) begin
            r_state <= REQ;
            r_drop  <= 1'b0;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        HOLD:    r_state <= REQ;
        default: r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem_req_ready_i) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid_i) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= REQ;
            end else begin
              r_inst_buf <= imem_resp_data_i;
              r_state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (D_ready_i) begin
            r_pc    <= w_pc_next;
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign imem_req_valid_o = (r_state == REQ);
  assign imem_req_addr_o  = r_pc;
  assign f_valid_o        = (r_state == HOLD);
  assign f_inst_o         = f_valid_o ? r_inst_buf : NOP;
  assign f_pc_o           = f_valid_o ? r_pc : '0;
  assign f_pred_pc_o      = f_valid_o ? w_pc_next : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: the bench plays instruction memory and IF/ID,
// queueing each expected instruction when its response is driven.
module tb_ifu_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i;
  logic [31:0] imem_resp_data_i;
  logic        f_valid_o;
  logic        D_ready_i;
  logic [31:0] f_inst_o;
  logic [31:0] f_pc_o;
  logic [31:0] f_pred_pc_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t expQ[$];
  int     total = 0;
  int     bad   = 0;
  logic [31:0] curPc;

  ifu_fetch dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .f_valid_o         (f_valid_o),
    .D_ready_i         (D_ready_i),
    .f_inst_o          (f_inst_o),
    .f_pc_o            (f_pc_o),
    .f_pred_pc_o       (f_pred_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_fvalid"}, {31'd0, f_valid_o}, 32'd0);
    check({tag, "_finst"},  f_inst_o,    32'h13);
    check({tag, "_fpc"},    f_pc_o,      32'd0);
    check({tag, "_fpred"},  f_pred_pc_o, 32'd0);
  endtask

  // In REQ: check the request, let memory accept it -> WAIT
  task automatic reqCycle(input logic [31:0] addr);
    check("req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("req_addr",  imem_req_addr_o, addr);
    imem_req_ready_i = 1'b1;
    tick();
    imem_req_ready_i = 1'b0;
    check("wait_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    check("wait_fvalid", {31'd0, f_valid_o}, 32'd0);
  endtask

  // In WAIT: return a good response -> HOLD
  task automatic respCycle(input logic [31:0] pc, input logic [31:0] data);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i  = data;
    expQ.push_back('{pc: pc, inst: data});
    tick();
    imem_resp_valid_i = 1'b0;
  endtask

  task automatic checkHead(input string tag);
    fetch_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL %s_empty observed=0 expected=1", tag);
    end else begin
      e = expQ.pop_front();
      check({tag, "_fvalid"}, {31'd0, f_valid_o}, 32'd1);
      check({tag, "_fpc"},    f_pc_o,      e.pc);
      check({tag, "_finst"},  f_inst_o,    e.inst);
      check({tag, "_fpred"},  f_pred_pc_o, e.pc + 32'd4);
    end
  endtask

  task automatic consume(input string tag);
    checkHead(tag);
    D_ready_i = 1'b1;
    tick();
    D_ready_i = 1'b0;
  endtask

  task automatic applyReset();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    imem_resp_data_i = '0;
    D_ready_i = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("rst_req_addr", imem_req_addr_o, 32'h8000_0000);
    checkIdle("rst");
    rst_i = 1'b1;

    // Free-running memory with IF/ID always ready
    for (int i = 0; i < 3; i++) begin
      curPc = 32'h8000_0000 + 32'(i * 4);
      reqCycle(curPc);
      respCycle(curPc, 32'h0000_0013 | 32'(i << 20));
      consume("free");
    end
    check("free_next_addr", imem_req_addr_o, 32'h8000_000C);

    // Backpressure in HOLD
    applyReset();
    reqCycle(32'h8000_0000);
    respCycle(32'h8000_0000, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      check("bp_fvalid", {31'd0, f_valid_o}, 32'd1);
      check("bp_finst", f_inst_o, 32'h0050_0093);
      check("bp_fpc", f_pc_o, 32'h8000_0000);
      check("bp_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      tick();
    end
    consume("bp");
    check("bp_next_addr", imem_req_addr_o, 32'h8000_0004);

    // Redirect while waiting for a response
    reqCycle(32'h8000_0004);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    tick();
    redirect_valid_i = 1'b0;
    check("rw_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid_i = 1'b0;
    checkIdle("rw_drop");
    reqCycle(32'h8000_0100);
    respCycle(32'h8000_0100, 32'h1111_1111);
    consume("rw");

    // Redirect in REQ to reach 0x80000010, then redirect together with D_ready in HOLD
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0010;
    tick();
    redirect_valid_i = 1'b0;
    reqCycle(32'h8000_0010);
    respCycle(32'h8000_0010, 32'h2222_2222);
    checkHead("rh");
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0040;
    D_ready_i = 1'b1;
    tick();
    redirect_valid_i = 1'b0;
    D_ready_i = 1'b0;
    check("rh_addr", imem_req_addr_o, 32'h8000_0040);
    checkIdle("rh");

    // Redirect in REQ while memory stalls
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_valid_i = 1'b0;
    check("rr_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check("rr_addr", imem_req_addr_o, 32'h8000_0200);

    // Redirect coinciding with the response in WAIT
    reqCycle(32'h8000_0200);
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0300;
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hBAD0_0001;
    tick();
    redirect_valid_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    check("rwr_addr", imem_req_addr_o, 32'h8000_0300);
    checkIdle("rwr");

    // Reset during WAIT; the stale response must be ignored
    reqCycle(32'h8000_0300);
    applyReset();
    imem_resp_valid_i = 1'b1;
    imem_resp_data_i = 32'hBAD0_0002;
    check("rst_wait_addr", imem_req_addr_o, 32'h8000_0000);
    tick();
    imem_resp_valid_i = 1'b0;
    check("rst_stale_req", {31'd0, imem_req_valid_o}, 32'd1);
    check("rst_stale_addr", imem_req_addr_o, 32'h8000_0000);
    checkIdle("rst_stale");
    reqCycle(32'h8000_0000);
    respCycle(32'h8000_0000, 32'h3333_3333);
    consume("rst_after");

    // PC wrap-around
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    reqCycle(32'hFFFF_FFFC);
    respCycle(32'hFFFF_FFFC, 32'h4444_4444);
    check("wrap_pred", f_pred_pc_o, 32'h0000_0000);
    consume("wrap");
    check("wrap_addr", imem_req_addr_o, 32'h0000_0000);

    check("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Sits between the instruction-memory port and the IF/ID pipeline register.
- Holds the architectural fetch PC and issues one read request at a time to instruction memory.
- Buffers the returned instruction and presents it downstream with a valid/ready handshake (f_valid_o / D_ready_i).
- Accepts redirects from later stages: the fetch PC jumps to the target and any in-flight fetch is squashed.

Parameters:
- PC_W, 32, width of PC and memory address.
- INST_W, 32, width of instruction word.
- RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-low reset.
- redirect_valid_i  input  1  redirect request from EXU/WBU; single-cycle pulse.
- redirect_pc_i  input  PC_W  redirect target; sampled when redirect_valid_i=1.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_req_addr_o  output  PC_W  fetch address.
- imem_resp_valid_i  input  1  read data valid; one response per accepted request, in order.
- imem_resp_data_i  input  INST_W  instruction word.
- f_valid_o  output  1  buffered instruction valid, to IF/ID.
- D_ready_i  input  1  IF/ID can accept.
- f_inst_o  output  INST_W  buffered instruction.
- f_pc_o  output  PC_W  PC of buffered instruction.
- f_pred_pc_o  output  PC_W  predicted next PC (f_pc_o+4).

Behaviour:
- States: REQ, WAIT, HOLD. Registers: pc, inst_buf, drop.
- Reset (rst_i=0 at a clock edge):
  - state=REQ, pc=RESET_PC, drop=0, inst_buf=32'h13.
  - Outputs in the cycle after reset: imem_req_valid_o=1, imem_req_addr_o=RESET_PC, f_valid_o=0, f_inst_o=32'h13, f_pc_o=0, f_pred_pc_o=0.
  - Reset mid-operation abandons any outstanding request. Responses arriving while in REQ are ignored.
- Output decoding (Moore):
  - imem_req_valid_o=(state==REQ); imem_req_addr_o=pc.
  - f_valid_o=(state==HOLD).
  - When f_valid_o=0: f_inst_o=32'h13 (nop), f_pc_o=0, f_pred_pc_o=0.
  - When f_valid_o=1: f_inst_o=inst_buf, f_pc_o=pc, f_pred_pc_o=pc+4, wrapping mod 2^PC_W.
- REQ state:
  - req_ready=1 -> WAIT.
  - req_ready=0 -> stay in REQ. The request may be retracted or have its address changed before acceptance; the memory port tolerates this.
- WAIT state, on resp_valid=1:
  - drop=0 -> inst_buf<=resp_data, go to HOLD.
  - drop=1 -> discard the data, drop<=0, go to REQ.
  - resp_valid while in REQ or HOLD is ignored.
- HOLD state:
  - D_ready_i=1 -> pc<=pc+4 (wraps), go to REQ.
  - D_ready_i=0 -> hold; f_valid_o, f_inst_o and f_pc_o stay stable.
- Redirect (redirect_valid_i=1) has priority over every other event in the same cycle; pc<=redirect_pc_i in all cases:
  - REQ with req_ready=0: stay in REQ; next cycle requests the target.
  - REQ with req_ready=1: the old request is accepted, go to WAIT with drop<=1.
  - WAIT without resp_valid: drop<=1, stay in WAIT.
  - WAIT with resp_valid in the same cycle: discard the data, go to REQ, drop<=0.
  - HOLD (including with D_ready_i=1): the instruction is not incremented past; go to REQ. f_valid_o=0 in the next cycle. Whether the instruction was consumed by IF/ID that cycle is the downstream's concern; the redirect source squashes it.
- Latency: with req_ready and resp_valid both asserted immediately, a new instruction is presented every 3 cycles (REQ->WAIT->HOLD). Each extra memory wait cycle adds one cycle.
- At most one outstanding request at any time.

Test Plan:
- Reset then free-running memory (req_ready=1, resp one cycle after accept, D_ready_i=1):
  - Required: addresses 0x80000000, 0x80000004, 0x80000008.
  - f_valid_o pulses every 3rd cycle with matching f_pc_o, and f_pred_pc_o=f_pc_o+4.
- Backpressure: D_ready_i=0 for 5 cycles in HOLD with inst 0x00500093 at 0x80000000.
  - Required: f_valid_o=1 and outputs stable throughout; no new imem request.
  - The next request goes to 0x80000004 only after D_ready_i=1.
- Redirect in WAIT: request 0x80000004 accepted, then redirect_pc_i=0x80000100 before the response.
  - Required: the response is discarded with f_valid_o=0, then a request to 0x80000100 is issued.
  - The next valid has f_pc_o=0x80000100.
- Simultaneous redirect and D_ready_i=1 in HOLD at pc 0x80000010, target 0x80000040.
  - Required: the next request address is 0x80000040, not 0x80000014.
- Redirect in REQ with req_ready=0, target 0x80000200.
  - Required: the following cycle's imem_req_addr_o=0x80000200.
- Reset asserted in WAIT, with the stale response arriving next cycle.
  - Required: the response is ignored, a request to 0x80000000 is issued, and f_valid_o stays 0.
- Wrap-around: redirect to 0xFFFFFFFC.
  - Required: f_pred_pc_o=0x00000000, and the next fetch address after consumption is 0x00000000.
